// File: rtl/sprite_addr_pipe.sv
// Two-stage sprite-sheet address generator: maps the scan position to a ROM pixel
// address inside an animated, frame-latched sprite with horizontal wrap and mirroring.
module sprite_addr_pipe #(
  parameter int H_WRAP      = 850,
  parameter int ADDR_W      = 17,
  parameter int SHEET_SIZE  = 27000,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 8,
  parameter int FI_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              pix_valid,
  input  logic [9:0]        loc_h,
  input  logic [9:0]        loc_v,
  input  logic [9:0]        width,
  input  logic [9:0]        height,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_hit,
  output logic [FI_W-1:0]   frame_idx
);

  localparam int SW   = ADDR_W + 1;
  localparam int TK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [10:0]     H_WRAP_W  = 11'(H_WRAP);
  localparam logic [SW-1:0]   SHEET_W   = SW'(SHEET_SIZE);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(FRAME_TICKS - 1);
  localparam logic [FI_W-1:0] IDX_LAST  = FI_W'(NUM_FRAMES - 1);

  // Column offset from the sprite's left edge, wrapping across the right screen edge.
  function automatic logic [10:0] wrap_dx(input logic [10:0] h, input logic [10:0] lh);
    if (h >= lh) return h - lh;
    else         return h + H_WRAP_W - lh;
  endfunction

  // Single conditional subtraction keeps the address inside the ROM depth.
  function automatic logic [ADDR_W-1:0] sheet_reduce(input logic [SW-1:0] sum);
    if (sum >= SHEET_W) return ADDR_W'(sum - SHEET_W);
    else                return ADDR_W'(sum);
  endfunction

  logic [9:0]        loc_h_s, loc_v_s, width_s, height_s;
  logic              flip_s;
  logic [TK_W-1:0]   tick;
  logic [ADDR_W-1:0] frame_base;
  logic [19:0]       size_c;

  assign size_c = {10'd0, width} * {10'd0, height};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loc_h_s  <= '0;
      loc_v_s  <= '0;
      width_s  <= '0;
      height_s <= '0;
      flip_s   <= 1'b0;
    end else if (frame_start) begin
      loc_h_s  <= loc_h;
      loc_v_s  <= loc_v;
      width_s  <= width;
      height_s <= height;
      flip_s   <= flip_h;
    end
  end

  // Restart wins over an advance; the step size is the geometry latched on this same frame_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick       <= '0;
      frame_idx  <= '0;
      frame_base <= '0;
    end else if (anim_restart) begin
      tick       <= '0;
      frame_idx  <= '0;
      frame_base <= '0;
    end else if (frame_start && anim_en) begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        if (frame_idx == IDX_LAST) begin
          frame_idx  <= '0;
          frame_base <= '0;
        end else begin
          frame_idx  <= frame_idx + 1'b1;
          frame_base <= frame_base + ADDR_W'(size_c);
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  logic [10:0] h_ext, v_ext, lh_ext, lv_ext, w_ext, ht_ext;
  logic [10:0] dx_c, dy_c, rx_c;
  logic        hit_c;

  always_comb begin
    h_ext  = {1'b0, h_cnt};
    v_ext  = {1'b0, v_cnt};
    lh_ext = {1'b0, loc_h_s};
    lv_ext = {1'b0, loc_v_s};
    w_ext  = {1'b0, width_s};
    ht_ext = {1'b0, height_s};
    dx_c   = wrap_dx(h_ext, lh_ext);
    dy_c   = v_ext - lv_ext;
    hit_c  = pix_valid & (dx_c < w_ext) & (v_ext >= lv_ext) & (v_ext < lv_ext + ht_ext);
    rx_c   = flip_s ? (w_ext - 11'd1 - dx_c) : dx_c;
  end

  // ---- stage 1 register boundary ----
  logic              hit_p1;
  logic [10:0]       dy_p1, rx_p1;
  logic [9:0]        width_p1;
  logic [ADDR_W-1:0] base_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_p1   <= 1'b0;
      dy_p1    <= '0;
      rx_p1    <= '0;
      width_p1 <= '0;
      base_p1  <= '0;
    end else begin
      hit_p1   <= hit_c;
      dy_p1    <= dy_c;
      rx_p1    <= rx_c;
      width_p1 <= width_s;
      base_p1  <= frame_base;
    end
  end

  logic [SW-1:0] prod_c, sum_c;

  always_comb begin
    prod_c = SW'(dy_p1) * SW'(width_p1);
    sum_c  = SW'(base_p1) + prod_c + SW'(rx_p1);
  end

  // ---- stage 2 register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      pixel_hit  <= 1'b0;
    end else begin
      pixel_addr <= hit_p1 ? sheet_reduce(sum_c) : '0;
      pixel_hit  <= hit_p1;
    end
  end

endmodule

// File: tb/tb_sprite_addr_pipe.sv
// Randomised and directed bench for sprite_addr_pipe against a frame-level behavioural model.
module tb_sprite_addr_pipe;
  localparam int NF = 3;
  localparam int FT = 2;
  localparam int HW = 850;
  localparam int AW = 17;
  localparam int SS = 27000;

  logic clk = 1'b0, rst = 1'b0;
  logic frame_start = 1'b0, pix_valid = 1'b0, flip_h = 1'b0, anim_en = 1'b0, anim_restart = 1'b0;
  logic [9:0] h_cnt = '0, v_cnt = '0, loc_h = '0, loc_v = '0, width = '0, height = '0;
  logic [AW-1:0] pixel_addr;
  logic pixel_hit;
  logic [1:0] frame_idx;

  sprite_addr_pipe #(
    .H_WRAP(HW), .ADDR_W(AW), .SHEET_SIZE(SS), .NUM_FRAMES(NF), .FRAME_TICKS(FT)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pix_valid(pix_valid), .loc_h(loc_h), .loc_v(loc_v), .width(width), .height(height),
    .flip_h(flip_h), .anim_en(anim_en), .anim_restart(anim_restart),
    .pixel_addr(pixel_addr), .pixel_hit(pixel_hit), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_lh, m_lv, m_w, m_h, m_flip, m_tick, m_fidx, m_base;
  int exp_q[$];
  int obs_hit, obs_addr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_lh = 0; m_lv = 0; m_w = 0; m_h = 0; m_flip = 0;
    m_tick = 0; m_fidx = 0; m_base = 0;
    exp_q.delete();
    exp_q.push_back(0);
  endtask

  // Expected {hit, addr} for one pixel, from the current shadow geometry and animation state.
  function automatic int model_pix(input int h, input int v, input bit pv);
    int dx, rx, sum;
    bit hit;
    dx  = (h >= m_lh) ? h - m_lh : h + HW - m_lh;
    hit = pv && (dx < m_w) && (v >= m_lv) && (v < m_lv + m_h);
    if (!hit) return 0;
    rx  = m_flip ? m_w - 1 - dx : dx;
    sum = (m_base + (v - m_lv) * m_w + rx) % 262144;
    if (sum >= SS) sum -= SS;
    return (1 << 20) | (sum % 131072);
  endfunction

  task automatic step(input bit fs, input bit rs, input int h, input int v, input bit pv);
    int e;
    frame_start = fs; anim_restart = rs; pix_valid = pv;
    h_cnt = 10'(h); v_cnt = 10'(v);
    exp_q.push_back(model_pix(h, v, pv));
    if (rs) begin
      m_tick = 0; m_fidx = 0; m_base = 0;
    end else if (fs && anim_en) begin
      m_tick++;
      if (m_tick == FT) begin
        m_tick = 0;
        if (m_fidx == NF - 1) begin
          m_fidx = 0; m_base = 0;
        end else begin
          m_fidx++;
          m_base = (m_base + int'(width) * int'(height)) % 131072;
        end
      end
    end
    if (fs) begin
      m_lh = int'(loc_h); m_lv = int'(loc_v); m_w = int'(width); m_h = int'(height);
      m_flip = int'(flip_h);
    end
    @(posedge clk); #1;
    frame_start = 1'b0; anim_restart = 1'b0; pix_valid = 1'b0;
    e = exp_q.pop_front();
    obs_hit = int'(pixel_hit); obs_addr = int'(pixel_addr);
    chk("pipe_hit", obs_hit, e >> 20);
    chk("pipe_addr", obs_addr, e & 'hFFFFF);
    chk("pipe_fidx", int'(frame_idx), m_fidx);
  endtask

  task automatic new_frame();
    step(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic probe(input int h, input int v, input bit pv, input int eh, input int ea,
                       input string tag);
    step(1'b0, 1'b0, h, v, pv);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk({tag, "_hit"}, obs_hit, eh);
    chk({tag, "_addr"}, obs_addr, ea);
  endtask

  task automatic set_geom(input int lh, input int lv, input int w, input int ht, input bit fl);
    loc_h = 10'(lh); loc_v = 10'(lv); width = 10'(w); height = 10'(ht); flip_h = fl;
  endtask

  int seq[6] = '{0, 1, 1, 2, 2, 0};
  int h, v;

  initial begin
    // Reset with arbitrary activity on the inputs
    rst = 1'b0;
    repeat (3) begin
      set_geom($urandom_range(0, 849), $urandom_range(0, 500), $urandom_range(1, 300),
               $urandom_range(1, 300), 1'($urandom_range(0, 1)));
      frame_start = 1'($urandom_range(0, 1)); pix_valid = 1'b1; anim_en = 1'b1;
      h_cnt = 10'($urandom_range(0, 849)); v_cnt = 10'($urandom_range(0, 500));
      @(posedge clk); #1;
      chk("rst_hit", int'(pixel_hit), 0);
      chk("rst_addr", int'(pixel_addr), 0);
      chk("rst_fidx", int'(frame_idx), 0);
    end
    frame_start = 1'b0; pix_valid = 1'b0; anim_en = 1'b0;
    rst = 1'b1;
    model_reset();
    probe(int'(loc_h), int'(loc_v), 1'b1, 0, 0, "rst_hold");
    probe(0, 0, 1'b1, 0, 0, "rst_hold0");

    // Basic hit
    set_geom(100, 50, 40, 30, 1'b0);
    new_frame();
    probe(100, 50, 1'b1, 1, 0, "basic_tl");
    probe(139, 79, 1'b1, 1, 1199, "basic_br");
    probe(140, 50, 1'b1, 0, 0, "basic_right");
    probe(100, 50, 1'b0, 0, 0, "basic_nvld");

    // Horizontal wrap
    set_geom(830, 0, 40, 30, 1'b0);
    new_frame();
    probe(849, 0, 1'b1, 1, 19, "wrap_849");
    probe(5, 0, 1'b1, 1, 25, "wrap_5");
    probe(20, 0, 1'b1, 0, 0, "wrap_20");

    // Mirroring
    set_geom(100, 50, 40, 30, 1'b1);
    new_frame();
    probe(100, 50, 1'b1, 1, 39, "flip_tl");
    probe(139, 51, 1'b1, 1, 40, "flip_r1");

    // Animation sequencing and restart
    set_geom(100, 50, 40, 30, 1'b0);
    anim_en = 1'b1;
    step(1'b0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      new_frame();
      chk("anim_seq", int'(frame_idx), seq[i]);
      if (i == 1) probe(100, 50, 1'b1, 1, 1200, "anim_f1");
    end
    new_frame();
    new_frame();
    chk("anim_pre_restart", int'(frame_idx), 1);
    step(1'b1, 1'b1, 0, 0, 1'b0);
    chk("anim_restart", int'(frame_idx), 0);

    // Sheet overflow and mid-frame geometry change
    step(1'b0, 1'b1, 0, 0, 1'b0);
    set_geom(0, 0, 1000, 13, 1'b0);
    repeat (4) new_frame();
    chk("ovf_fidx", int'(frame_idx), 2);
    anim_en = 1'b0;
    new_frame();
    probe(500, 1, 1'b1, 1, 500, "ovf_addr");
    loc_h = 10'd400;
    probe(500, 1, 1'b1, 1, 500, "midframe_hold");
    new_frame();
    probe(500, 1, 1'b1, 1, 100, "midframe_apply");

    // Randomised traffic including frame_start/pixel coincidence and restarts
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_geom($urandom_range(0, 849), $urandom_range(0, 500),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 300),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 200),
                 1'($urandom_range(0, 1)));
        anim_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        h = (m_lh + int'($urandom_range(0, 302))) % HW;
        v = m_lv + int'($urandom_range(0, 202)) - 1;
        if (v < 0) v = 0;
      end else begin
        h = $urandom_range(0, 849);
        v = $urandom_range(0, 1023);
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, h, v,
           $urandom_range(0, 7) != 0);
    end

    // Asynchronous reset in the middle of a cycle
    set_geom(100, 50, 40, 30, 1'b0);
    new_frame();
    step(1'b0, 1'b0, 100, 50, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_hit", int'(pixel_hit), 0);
    chk("async_rst_addr", int'(pixel_addr), 0);
    chk("async_rst_fidx", int'(frame_idx), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    probe(100, 50, 1'b1, 0, 0, "post_rst_nohit");
    new_frame();
    probe(139, 79, 1'b1, 1, 1199, "post_rst_hit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
